// File: rtl/t09_snake_game_sequencer.sv
// Snake game sequencer: turns move ticks into sync strobes, waits for the datapath
// to settle, then scores wall/body/apple results and tracks length, score and game state.
module t09_snake_game_sequencer #(
  parameter int MAX_LENGTH  = 50,
  parameter int INIT_LENGTH = 3,
  parameter int SETTLE_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       move_tick,
  input  logic       wall_hit,
  input  logic       body_hit,
  input  logic       apple_hit,
  output logic       sync,
  output logic       apple_respawn,
  output logic [7:0] curr_length,
  output logic [7:0] score,
  output logic [2:0] state,
  output logic       game_over,
  output logic       game_win,
  output logic       tick_overrun
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_MOVE   = 3'd2,
    S_SETTLE = 3'd3,
    S_EVAL   = 3'd4,
    S_OVER   = 3'd5,
    S_WIN    = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         score_q, score_d;
  logic               sync_q, sync_d;
  logic               resp_q, resp_d;
  logic               ovr_q, ovr_d;
  logic               over_q, over_d;
  logic               win_q, win_d;

  logic collide;
  logic grow;
  logic busy;

  assign collide = wall_hit | body_hit;
  // An apple that does not complete the body keeps the game running and needs a new apple.
  assign grow    = (state_q == S_EVAL) && !collide && apple_hit &&
                   (len_q != 8'(MAX_LENGTH - 1));
  assign busy    = (state_q == S_MOVE) || (state_q == S_SETTLE) || (state_q == S_EVAL);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= 8'(INIT_LENGTH);
      score_q <= '0;
      sync_q  <= 1'b0;
      resp_q  <= 1'b0;
      ovr_q   <= 1'b0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      score_q <= score_d;
      sync_q  <= sync_d;
      resp_q  <= resp_d;
      ovr_q   <= ovr_d;
      over_q  <= over_d;
      win_q   <= win_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    score_d = score_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_WAIT;
      S_WAIT: if (move_tick) state_d = S_MOVE;
      S_MOVE: begin
        cnt_d   = CNT_W'(SETTLE_CYC);
        state_d = (SETTLE_CYC == 0) ? S_EVAL : S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (collide) begin
          state_d = S_OVER;
        end else if (apple_hit) begin
          len_d   = len_q + 8'd1;
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          state_d = (len_q == 8'(MAX_LENGTH - 1)) ? S_WIN : S_WAIT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_OVER, S_WIN: begin
        if (start) begin
          state_d = S_IDLE;
          len_d   = 8'(INIT_LENGTH);
          score_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sync_d = (state_d == S_MOVE);
    resp_d = ((state_q == S_IDLE) && start) || grow;
    ovr_d  = busy && move_tick;
    over_d = (state_d == S_OVER);
    win_d  = (state_d == S_WIN);
  end

  assign sync          = sync_q;
  assign apple_respawn = resp_q;
  assign tick_overrun  = ovr_q;
  assign curr_length   = len_q;
  assign score         = score_q;
  assign state         = state_q;
  assign game_over     = over_q;
  assign game_win      = win_q;

endmodule
